// File: rtl/serial_sample_bank_loader.sv
// Double-buffered sample bank loader: HPS writes LANES samples per four-phase
// handshake into a shadow bank, and a commit publishes it to the active bank.
module serial_sample_bank_loader #(
    parameter int NUM_SAMPLES = 32,
    parameter int LANES       = 4,
    parameter int DATA_W      = 8,
    parameter int IDX_W       = 32
) (
    input  logic                                    iClock,
    input  logic                                    iReset,
    input  logic [LANES*DATA_W-1:0]                 iSampleInput,
    input  logic [LANES*DATA_W-1:0]                 iSampleExpected,
    input  logic [LANES*DATA_W-1:0]                 iSampleValid,
    input  logic [IDX_W-1:0]                        iSampleIndex,
    input  logic                                    iWriteSample,
    input  logic                                    iCommit,
    input  logic                                    iClearShadow,
    input  logic                                    iConsumerBusy,
    output logic                                    oNextSample,
    output logic                                    oCommitDone,
    output logic [NUM_SAMPLES*DATA_W-1:0]           oInputSequences,
    output logic [NUM_SAMPLES*DATA_W-1:0]           oExpectedOutputs,
    output logic [NUM_SAMPLES*DATA_W-1:0]           oValidOutputs,
    output logic [$clog2(NUM_SAMPLES/LANES):0]      oLoadedWords,
    output logic                                    oIndexError,
    output logic [1:0]                              oState
);

    localparam int WORDS  = NUM_SAMPLES / LANES;
    localparam int CNT_W  = $clog2(WORDS) + 1;
    localparam int WORD_W = LANES * DATA_W;
    localparam int BANK_W = NUM_SAMPLES * DATA_W;
    localparam logic [IDX_W-1:0] WORDS_IDX = IDX_W'(WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [WORDS-1:0]    mask_q, mask_d;
    logic [CNT_W-1:0]    loaded_q, loaded_d;
    logic                wr_arm_q, wr_arm_d;
    logic                cm_arm_q, cm_arm_d;
    logic [BANK_W-1:0]   sh_in_q, sh_in_d;
    logic [BANK_W-1:0]   sh_exp_q, sh_exp_d;
    logic [BANK_W-1:0]   sh_val_q, sh_val_d;
    logic [BANK_W-1:0]   act_in_q, act_in_d;
    logic [BANK_W-1:0]   act_exp_q, act_exp_d;
    logic [BANK_W-1:0]   act_val_q, act_val_d;

    function automatic logic [CNT_W-1:0] popcount(input logic [WORDS-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WORDS; i++) begin
            c = c + CNT_W'(m[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        done_d    = done_q;
        // A clear pulse lands before any write in the same cycle.
        err_d     = iClearShadow ? 1'b0 : err_q;
        mask_d    = iClearShadow ? '0 : mask_q;
        // Requests are honoured only once their level has been seen low,
        // so a request left high across a reset is not replayed.
        wr_arm_d  = wr_arm_q | ~iWriteSample;
        cm_arm_d  = cm_arm_q | ~iCommit;
        sh_in_d   = sh_in_q;
        sh_exp_d  = sh_exp_q;
        sh_val_d  = sh_val_q;
        act_in_d  = act_in_q;
        act_exp_d = act_exp_q;
        act_val_d = act_val_q;

        case (state_q)
            IDLE: begin
                if (iWriteSample && wr_arm_q) begin
                    state_d = WRITE;
                end else if (iCommit && cm_arm_q && !iConsumerBusy) begin
                    state_d = COMMIT;
                end
            end
            WRITE: begin
                if (iSampleIndex < WORDS_IDX) begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (iSampleIndex == IDX_W'(w)) begin
                            mask_d[w]                     = 1'b1;
                            sh_in_d[w*WORD_W +: WORD_W]  = iSampleInput;
                            sh_exp_d[w*WORD_W +: WORD_W] = iSampleExpected;
                            sh_val_d[w*WORD_W +: WORD_W] = iSampleValid;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!iWriteSample) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                // The copy happens once, on the first COMMIT cycle; the rest
                // of the state only waits for the request to be withdrawn.
                if (!done_q) begin
                    act_in_d  = sh_in_q;
                    act_exp_d = sh_exp_q;
                    act_val_d = sh_val_q;
                    done_d    = 1'b1;
                end else if (!iCommit) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        loaded_d = popcount(mask_d);
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            mask_q    <= '0;
            loaded_q  <= '0;
            wr_arm_q  <= 1'b0;
            cm_arm_q  <= 1'b0;
            sh_in_q   <= '0;
            sh_exp_q  <= '0;
            sh_val_q  <= '0;
            act_in_q  <= '0;
            act_exp_q <= '0;
            act_val_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
            loaded_q  <= loaded_d;
            wr_arm_q  <= wr_arm_d;
            cm_arm_q  <= cm_arm_d;
            sh_in_q   <= sh_in_d;
            sh_exp_q  <= sh_exp_d;
            sh_val_q  <= sh_val_d;
            act_in_q  <= act_in_d;
            act_exp_q <= act_exp_d;
            act_val_q <= act_val_d;
        end
    end

    assign oNextSample      = ack_q;
    assign oCommitDone      = done_q;
    assign oInputSequences  = act_in_q;
    assign oExpectedOutputs = act_exp_q;
    assign oValidOutputs    = act_val_q;
    assign oLoadedWords     = loaded_q;
    assign oIndexError      = err_q;
    assign oState           = state_q;

endmodule
